// File: rtl/fresh_range_loader.sv
// fresh_range_loader
// Drains the fresh-range FIFO (standard mode, read latency 1) and expands each
// inclusive [begin, end] range into single-bit BRAM writes, one address per
// clock. Also runs a whole-table clear on request and reports load status.
//
// Ports:
//   clk, rst         fast clock (rising edge), asynchronous active-high reset
//   fifo_empty       range FIFO empty flag
//   fifo_rd_en       FIFO read strobe (one cycle per pop)
//   range_begin/end  FIFO dout: first / last address of the range (inclusive)
//   range_fresh      FIFO dout: bit value to write across the range
//   clear_req        single-cycle pulse: zero the entire table
//   ram_we/waddr/wdata  BRAM write port
//   busy             loader active or clear pending
//   table_stable     idle, FIFO empty, no clear pending (one cycle late)
//   range_err        sticky: a range with begin > end was popped
//   ranges_loaded    saturating count of ranges fully written
module fresh_range_loader #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [ADDR_W-1:0] range_begin,
  input  logic [ADDR_W-1:0] range_end,
  input  logic              range_fresh,
  input  logic              clear_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_wdata,
  output logic              busy,
  output logic              table_stable,
  output logic              range_err,
  output logic [CNT_W-1:0]  ranges_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    WRITE,
    CLEAR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] end_q;
  logic              clr_pend;

  // busy depends only on registered state, so it is a pure Moore decode.
  assign busy = (state != IDLE) || clr_pend;

  // ram_waddr doubles as the current address of a range or clear sweep, and
  // ram_wdata holds the latched fresh bit, so the write port is fully
  // registered without a separate copy of either.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fifo_rd_en    <= 1'b0;
      ram_we        <= 1'b0;
      ram_waddr     <= '0;
      ram_wdata     <= 1'b0;
      range_err     <= 1'b0;
      ranges_loaded <= '0;
      clr_pend      <= 1'b0;
      table_stable  <= 1'b0;
      end_q         <= '0;
    end else begin
      fifo_rd_en   <= 1'b0;
      table_stable <= (state == IDLE) && fifo_empty && !clr_pend;

      case (state)
        IDLE: begin
          if (clr_pend) begin
            clr_pend  <= 1'b0;
            ram_we    <= 1'b1;
            ram_waddr <= '0;
            ram_wdata <= 1'b0;
            state     <= CLEAR;
          end else if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            state      <= POP;
          end
        end

        POP: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          end_q <= range_end;
          if (range_begin > range_end) begin
            range_err <= 1'b1;
            state     <= IDLE;
          end else begin
            ram_we    <= 1'b1;
            ram_waddr <= range_begin;
            ram_wdata <= range_fresh;
            state     <= WRITE;
          end
        end

        WRITE: begin
          // Compare before increment so a range ending at the top address
          // stops without wrapping.
          if (ram_waddr == end_q) begin
            ram_we <= 1'b0;
            if (ranges_loaded != '1)
              ranges_loaded <= ranges_loaded + CNT_W'(1);
            state <= IDLE;
          end else begin
            ram_waddr <= ram_waddr + ADDR_W'(1);
          end
        end

        CLEAR: begin
          if (ram_waddr == '1) begin
            ram_we <= 1'b0;
            state  <= IDLE;
          end else begin
            ram_waddr <= ram_waddr + ADDR_W'(1);
          end
        end

        default: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // A request arriving in any cycle, including the one that enters
      // CLEAR, must leave a clear pending; placed last so it wins.
      if (clear_req)
        clr_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fresh_range_loader.sv
module tb_fresh_range_loader;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic [ADDR_W-1:0] range_begin = '0;
  logic [ADDR_W-1:0] range_end = '0;
  logic              range_fresh = 1'b0;
  logic              clear_req = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_wdata;
  logic              busy;
  logic              table_stable;
  logic              range_err;
  logic [CNT_W-1:0]  ranges_loaded;

  fresh_range_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .range_begin  (range_begin),
    .range_end    (range_end),
    .range_fresh  (range_fresh),
    .clear_req    (clear_req),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .busy         (busy),
    .table_stable (table_stable),
    .range_err    (range_err),
    .ranges_loaded(ranges_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {int b; int e; int f;} rng_t;
  typedef struct {int c; int a; int d;} wr_t;

  rng_t q[$];
  wr_t  wlog[$];
  int   rdlog[$];

  // Standard-mode FIFO model: dout updates on the edge after rd_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en === 1'b1 && q.size() > 0) begin
      range_begin <= 4'(q[0].b);
      range_end   <= 4'(q[0].e);
      range_fresh <= 1'(q[0].f);
      q.pop_front();
    end
    fifo_empty <= (q.size() == 0);
  end

  // Write/read monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (ram_we === 1'b1) wlog.push_back('{cyc, int'(ram_waddr), int'(ram_wdata)});
    if (fifo_rd_en === 1'b1) rdlog.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int b, input int e, input int f);
    q.push_back('{b, e, f});
  endtask

  task automatic wait_stable(input string tag, input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (table_stable !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_stable_timeout"}, 32'(table_stable), 1);
  endtask

  // Checks cnt consecutive-cycle writes starting at wlog[idx].
  task automatic check_run(input string tag, input int idx, input int a0, input int cnt, input int d);
    for (int k = 0; k < cnt; k++) begin
      if (idx + k < wlog.size()) begin
        chk({tag, "_addr"}, wlog[idx+k].a, a0 + k);
        chk({tag, "_data"}, wlog[idx+k].d, d);
        if (k > 0) chk({tag, "_consec"}, wlog[idx+k].c - wlog[idx+k-1].c, 1);
      end else begin
        chk({tag, "_missing"}, wlog.size(), idx + cnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  int n;
  int lows;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_waddr", 32'(ram_waddr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_table_stable", 32'(table_stable), 0);
    chk("rst_range_err", 32'(range_err), 0);
    chk("rst_ranges_loaded", 32'(ranges_loaded), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single range 3..6 fresh
    wlog.delete(); rdlog.delete();
    push(3, 6, 1);
    wait_stable("t1", 100);
    chk("t1_wr_count", wlog.size(), 4);
    check_run("t1", 0, 3, 4, 1);
    chk("t1_rd_pulses", rdlog.size(), 1);
    if (rdlog.size() > 0 && wlog.size() > 0)
      chk("t1_pop_to_write", wlog[0].c - rdlog[0], 2);
    chk("t1_ranges_loaded", 32'(ranges_loaded), 1);
    chk("t1_busy_idle", 32'(busy), 0);

    // T2: two single-address ranges at both ends of the table
    wlog.delete();
    push(0, 0, 1);
    push(15, 15, 0);
    wait_stable("t2", 100);
    chk("t2_wr_count", wlog.size(), 2);
    check_run("t2a", 0, 0, 1, 1);
    check_run("t2b", 1, 15, 1, 0);
    if (wlog.size() >= 2) chk("t2_gap", wlog[1].c - wlog[0].c, 4);
    chk("t2_ranges_loaded", 32'(ranges_loaded), 3);

    // T3: inverted range then a normal one
    wlog.delete();
    push(9, 2, 1);
    push(1, 2, 0);
    wait_stable("t3", 100);
    chk("t3_wr_count", wlog.size(), 2);
    check_run("t3", 0, 1, 2, 0);
    chk("t3_range_err", 32'(range_err), 1);
    chk("t3_ranges_loaded", 32'(ranges_loaded), 4);

    // T4: clear requested during the second write of 4..10
    wlog.delete();
    push(4, 10, 1);
    push(2, 3, 1);
    n = 0;
    while (!(ram_we === 1'b1 && ram_waddr == 4'd5) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_addr5", 32'(n < 50), 1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    lows = 0;
    while (!(ram_we === 1'b1 && ram_waddr == 4'd15 && ram_wdata === 1'b0) && n < 60) begin
      if (busy !== 1'b1) lows++;
      @(negedge clk);
      n++;
    end
    chk("t4_reach_clear_end", 32'(n < 60), 1);
    chk("t4_busy_low_cycles", lows, 0);
    wait_stable("t4", 100);
    chk("t4_wr_count", wlog.size(), 25);
    check_run("t4_range", 0, 4, 7, 1);
    check_run("t4_clear", 7, 0, 16, 0);
    check_run("t4_next", 23, 2, 2, 1);
    if (wlog.size() >= 25) begin
      chk("t4_gap_to_clear", wlog[7].c - wlog[6].c, 2);
      chk("t4_gap_to_next", wlog[23].c - wlog[22].c, 4);
    end
    chk("t4_ranges_loaded", 32'(ranges_loaded), 6);
    chk("t4_range_err_sticky", 32'(range_err), 1);

    // T5: reset mid-range at address 7
    push(0, 15, 1);
    push(5, 5, 1);
    n = 0;
    while (!(ram_we === 1'b1 && ram_waddr == 4'd7) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_addr7", 32'(n < 50), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ram_we", 32'(ram_we), 0);
    chk("t5_rst_ram_waddr", 32'(ram_waddr), 0);
    chk("t5_rst_ram_wdata", 32'(ram_wdata), 0);
    chk("t5_rst_fifo_rd_en", 32'(fifo_rd_en), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_table_stable", 32'(table_stable), 0);
    chk("t5_rst_range_err", 32'(range_err), 0);
    chk("t5_rst_ranges_loaded", 32'(ranges_loaded), 0);
    @(negedge clk);
    rst = 1'b0;
    wlog.delete();
    wait_stable("t5", 100);
    chk("t5_wr_count", wlog.size(), 1);
    check_run("t5", 0, 5, 1, 1);
    chk("t5_ranges_loaded", 32'(ranges_loaded), 1);

    // T6: counter saturation with 18 single-address ranges
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wlog.delete();
    for (int i = 0; i < 18; i++) push(i % 16, i % 16, 1);
    wait_stable("t6", 300);
    chk("t6_wr_count", wlog.size(), 18);
    if (wlog.size() >= 18) chk("t6_last_addr", wlog[17].a, 1);
    chk("t6_ranges_loaded_sat", 32'(ranges_loaded), 15);

    // T7: clear wins over queued FIFO data in IDLE
    wlog.delete();
    push(6, 6, 1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_stable("t7", 100);
    chk("t7_wr_count", wlog.size(), 17);
    check_run("t7_clear", 0, 0, 16, 0);
    check_run("t7_range", 16, 6, 1, 1);
    chk("t7_ranges_loaded", 32'(ranges_loaded), 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fresh_range_loader.md
Name: fresh_range_loader

Overview:
Sequencer that drains the fresh-range FIFO and expands each range into single-bit writes to the fresh-ingredient BRAM, one address per clock.
- Runs in the fast `clk` domain, between the range FIFO read port (standard mode, read latency 1) and the BRAM write port.
- Also provides a whole-table clear command.
- Reports load status so query logic knows when the table is stable.

Parameters:
- ADDR_W, 17, BRAM address width; table depth is 2^ADDR_W entries.
- CNT_W, 16, width of the loaded-range counter.

Ports:
- clk  in  1  fast processing clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  range FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- range_begin  in  ADDR_W  FIFO dout: first address of range.
- range_end  in  ADDR_W  FIFO dout: last address of range, inclusive.
- range_fresh  in  1  FIFO dout: value to write (1 = fresh, 0 = spoiled).
- clear_req  in  1  single-cycle pulse: zero entire table.
- ram_we  out  1  BRAM write enable.
- ram_waddr  out  ADDR_W  BRAM write address.
- ram_wdata  out  1  BRAM write data.
- busy  out  1  loader active or clear pending.
- table_stable  out  1  idle, FIFO empty, no clear pending.
- range_err  out  1  sticky: a range with begin > end was popped.
- ranges_loaded  out  CNT_W  count of ranges fully written; saturates at all-ones.

Behaviour:
- Reset (async, immediate) drives these values:
  - state = IDLE.
  - fifo_rd_en = 0, ram_we = 0, ram_waddr = 0, ram_wdata = 0.
  - range_err = 0, ranges_loaded = 0, clear pending = 0.
  - busy = 0, table_stable = 0.
- Reset mid-range or mid-clear abandons the operation. BRAM contents are not restored. A popped range is lost.
- All outputs are registered or Moore, decoded from state. No combinational path from inputs to outputs.
- FSM states: IDLE, POP, CAPTURE, WRITE, CLEAR.
- IDLE:
  - If clear pending: go to CLEAR.
  - Else if !fifo_empty: go to POP.
  - Else stay. table_stable = 1 only in IDLE with fifo_empty = 1 and no clear pending, registered one cycle late.
- POP:
  - fifo_rd_en = 1 for exactly this one cycle.
  - Always go to CAPTURE next. fifo_empty is not re-checked.
- CAPTURE:
  - FIFO dout is valid this cycle. Latch begin, end and fresh.
  - If begin > end (unsigned): set range_err, do not increment ranges_loaded, go to IDLE. No writes are issued.
  - Else cur_addr = begin; go to WRITE.
- WRITE:
  - Each cycle: ram_we = 1, ram_waddr = cur_addr, ram_wdata = latched fresh.
  - If cur_addr == end: increment ranges_loaded (saturating), go to IDLE.
  - Else cur_addr + 1.
  - Compare before increment, so end = 2^ADDR_W-1 terminates without wrap.
  - begin == end gives exactly one write.
- Timing:
  - A range of N addresses produces N consecutive ram_we cycles.
  - First write appears 3 cycles after the IDLE cycle that saw fifo_empty = 0.
  - Back-to-back ranges leave exactly 3 ram_we = 0 cycles between them (IDLE, POP, CAPTURE).
- CLEAR:
  - Writes wdata = 0 to addresses 0 .. 2^ADDR_W-1 on consecutive cycles, then goes to IDLE.
  - Clear pending drops on entry to CLEAR.
  - ranges_loaded is unchanged by a clear.
- clear_req rules:
  - Sets clear pending in any state.
  - Arriving during WRITE: the current range completes, then CLEAR runs before the next pop.
  - Arriving during CLEAR: sets pending again, so a second full clear follows.
  - Clear has priority over FIFO data in IDLE.
- busy = (state != IDLE) or clear pending.
- fifo_rd_en is never asserted while fifo_empty = 1 in the same IDLE-decision cycle.
- If a pop would not otherwise run, FIFO underflow is not possible.

Test Plan:
- ADDR_W = 4. FIFO supplies {begin=3, end=6, fresh=1} → after the POP cycle, exactly 4 consecutive ram_we cycles with addresses 3, 4, 5, 6 and wdata = 1; ranges_loaded = 1; table_stable rises after return to IDLE.
- Two queued ranges {0, 0, 1} and {15, 15, 0} → one write at address 0, then 3 idle cycles, then one write at address 15 with wdata = 0; no address wrap; ranges_loaded = 2.
- Range {9, 2, 1} → zero writes, range_err = 1 and stays set, ranges_loaded unchanged, next range processes normally.
- clear_req pulsed during the second write of {4, 10, 1} → addresses 4–10 complete, then 16 writes of 0 covering addresses 0–15, then the next queued range pops; busy stays high throughout.
- Assert rst during a WRITE of {0, 15, 1} at address 7 → outputs go to reset values immediately; after release, FSM idles and the next queued range is popped.
- ranges_loaded preloaded via 2^CNT_W+2 single-address ranges (CNT_W = 4 build) → counter saturates at 15.
